// File: rtl/mem_stage.sv
// mem_stage: memory-access pipeline stage.
//
// Takes the EX/MEM register outputs and produces registered MEM/WB writeback values. It owns a
// word-addressed data memory with a fixed multi-cycle access latency. While an access is in
// flight, a combinational stall holds the EX/MEM register. Non-memory instructions pass
// through in a single edge.
//
// Parameters
//   DEPTH         data memory size in 32-bit words (power of 2, >= 2)
//   LATENCY       access cycles per memory op (>= 1)
// Ports
//   clk           clock, rising edge
//   rst           asynchronous active-high reset
//   addr_in       ALU result; byte address for memory ops
//   store_data_in store data
//   rd_in         destination register
//   mem_read      load request
//   mem_write     store request (wins over mem_read when both are set)
//   stall         combinational; EX/MEM must hold while high
//   wb_data_out   registered writeback data
//   rd_out        registered destination register
//   wb_valid      registered; MEM/WB writes rd_out when high
//   align_err     registered one-cycle pulse for a misaligned memory op
module mem_stage #(
  parameter int unsigned DEPTH   = 256,
  parameter int unsigned LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr_in,
  input  logic [31:0] store_data_in,
  input  logic [4:0]  rd_in,
  input  logic        mem_read,
  input  logic        mem_write,
  output logic        stall,
  output logic [31:0] wb_data_out,
  output logic [4:0]  rd_out,
  output logic        wb_valid,
  output logic        align_err
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(LATENCY) + 1;

  typedef enum logic [0:0] {StIdle, StAccess} state_e;

  state_e          state_q;
  logic [CW-1:0]   cnt_q;
  logic [AW-1:0]   addr_q;
  logic [31:0]     data_q;
  logic [4:0]      rd_q;
  logic            wr_q;

  logic [31:0]     mem [DEPTH];
  logic [31:0]     mem_rdata;
  logic            mem_we;

  logic            mem_op;
  logic            misaligned;
  logic [AW-1:0]   idx;
  logic            last_cycle;

  // Upper address bits only select an alias of the memory; they are deliberately dropped.
  logic            unused_addr;
  assign unused_addr = ^addr_in[31:AW+2];

  always_comb begin
    mem_op     = mem_read | mem_write;
    misaligned = |addr_in[1:0];
    idx        = addr_in[AW+1:2];
    last_cycle = (state_q == StAccess) && (cnt_q == '0);
  end

  // Stall never looks at memory data, so there is no path from the array to EX/MEM.
  always_comb begin
    stall = 1'b0;
    if (!rst) begin
      unique case (state_q)
        StIdle:   stall = mem_op & ~misaligned;
        StAccess: stall = (cnt_q != '0);
        default:  stall = 1'b0;
      endcase
    end
  end

  // Only latched copies are used once the access has started.
  assign mem_rdata = mem[addr_q];
  assign mem_we    = last_cycle & wr_q & ~rst;

  // Memory contents survive reset, so the array has no reset branch.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[addr_q] <= data_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      rd_q        <= '0;
      wr_q        <= 1'b0;
      wb_data_out <= '0;
      rd_out      <= '0;
      wb_valid    <= 1'b0;
      align_err   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (!mem_op) begin
            // Plain ALU result passes straight through.
            wb_data_out <= addr_in;
            rd_out      <= rd_in;
            wb_valid    <= (rd_in != '0);
            align_err   <= 1'b0;
          end else if (misaligned) begin
            // Dropped op: no access, no stall, squashed writeback.
            wb_data_out <= '0;
            rd_out      <= '0;
            wb_valid    <= 1'b0;
            align_err   <= 1'b1;
          end else begin
            addr_q    <= idx;
            data_q    <= store_data_in;
            rd_q      <= rd_in;
            wr_q      <= mem_write;
            cnt_q     <= CW'(LATENCY - 1);
            state_q   <= StAccess;
            wb_valid  <= 1'b0;
            align_err <= 1'b0;
          end
        end
        StAccess: begin
          align_err <= 1'b0;
          if (cnt_q != '0) begin
            cnt_q    <= cnt_q - 1'b1;
            wb_valid <= 1'b0;
          end else begin
            if (wr_q) begin
              rd_out   <= '0;
              wb_valid <= 1'b0;
            end else begin
              wb_data_out <= mem_rdata;
              rd_out      <= rd_q;
              wb_valid    <= (rd_q != '0);
            end
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage (DEPTH=256, LATENCY=2) with hand-computed expectations.
module tb_mem_stage;

  logic        clk;
  logic        rst;
  logic [31:0] addr_in;
  logic [31:0] store_data_in;
  logic [4:0]  rd_in;
  logic        mem_read;
  logic        mem_write;
  logic        stall;
  logic [31:0] wb_data_out;
  logic [4:0]  rd_out;
  logic        wb_valid;
  logic        align_err;

  int n_total;
  int n_bad;
  int stalls;
  int edges;

  mem_stage #(
    .DEPTH  (256),
    .LATENCY(2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .addr_in      (addr_in),
    .store_data_in(store_data_in),
    .rd_in        (rd_in),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .stall        (stall),
    .wb_data_out  (wb_data_out),
    .rd_out       (rd_out),
    .wb_valid     (wb_valid),
    .align_err    (align_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic drive_nop();
    addr_in       = 32'h0;
    store_data_in = 32'h0;
    rd_in         = 5'd0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
  endtask

  // Acts like EX/MEM: holds the op until an edge where stall was low, then drives a bubble.
  // Returns at posedge+1 of the advancing edge; counts stalled cycles and edges consumed.
  task automatic run_op(input logic [31:0] a, input logic [31:0] d, input logic [4:0] r,
                        input logic rdq, input logic wrq);
    logic s;
    bit   done;
    addr_in       = a;
    store_data_in = d;
    rd_in         = r;
    mem_read      = rdq;
    mem_write     = wrq;
    stalls        = 0;
    edges         = 0;
    done          = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      #1;
      s = stall;
      if (s) stalls++;
      @(posedge clk);
      edges++;
      if (!s) done = 1;
      else #2;
    end
    if (!done) check("op_timeout", 32'd0, 32'd1);
    #1;
    drive_nop();
  endtask

  initial begin
    n_total = 0;
    n_bad   = 0;
    drive_nop();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    // Under reset: outputs cleared and stall suppressed even for an aligned memory op.
    mem_read = 1'b1;
    addr_in  = 32'h40;
    #1;
    check("rst_stall", {31'd0, stall}, 32'd0);
    check("rst_wb_data", wb_data_out, 32'd0);
    check("rst_rd", {27'd0, rd_out}, 32'd0);
    check("rst_valid", {31'd0, wb_valid}, 32'd0);
    check("rst_align", {31'd0, align_err}, 32'd0);
    drive_nop();
    @(negedge clk);
    rst = 1'b0;

    // Pass-through.
    run_op(32'h1234, 32'h0, 5'd5, 1'b0, 1'b0);
    @(negedge clk);
    check("nop_stalls", stalls, 0);
    check("nop_data", wb_data_out, 32'h1234);
    check("nop_rd", {27'd0, rd_out}, 32'd5);
    check("nop_valid", {31'd0, wb_valid}, 32'd1);

    run_op(32'h77, 32'h0, 5'd0, 1'b0, 1'b0);
    @(negedge clk);
    check("nop_r0_data", wb_data_out, 32'h77);
    check("nop_r0_valid", {31'd0, wb_valid}, 32'd0);

    // Store then load at 0x10.
    run_op(32'h10, 32'hDEADBEEF, 5'd3, 1'b0, 1'b1);
    @(negedge clk);
    check("st_stalls", stalls, 2);
    check("st_valid", {31'd0, wb_valid}, 32'd0);
    check("st_rd", {27'd0, rd_out}, 32'd0);

    run_op(32'h10, 32'h0, 5'd7, 1'b1, 1'b0);
    @(negedge clk);
    check("ld_stalls", stalls, 2);
    check("ld_edges", edges, 3);
    check("ld_data", wb_data_out, 32'hDEADBEEF);
    check("ld_rd", {27'd0, rd_out}, 32'd7);
    check("ld_valid", {31'd0, wb_valid}, 32'd1);

    run_op(32'h10, 32'h0, 5'd0, 1'b1, 1'b0);
    @(negedge clk);
    check("ld_r0_data", wb_data_out, 32'hDEADBEEF);
    check("ld_r0_valid", {31'd0, wb_valid}, 32'd0);

    // Both request bits set: a store.
    run_op(32'h20, 32'h12345678, 5'd9, 1'b1, 1'b1);
    @(negedge clk);
    check("rw_valid", {31'd0, wb_valid}, 32'd0);
    check("rw_rd", {27'd0, rd_out}, 32'd0);
    run_op(32'h20, 32'h0, 5'd4, 1'b1, 1'b0);
    @(negedge clk);
    check("rw_ld_data", wb_data_out, 32'h12345678);
    check("rw_ld_rd", {27'd0, rd_out}, 32'd4);

    // Misaligned load and store.
    run_op(32'h13, 32'h0, 5'd6, 1'b1, 1'b0);
    @(negedge clk);
    check("mis_stalls", stalls, 0);
    check("mis_align", {31'd0, align_err}, 32'd1);
    check("mis_valid", {31'd0, wb_valid}, 32'd0);
    check("mis_rd", {27'd0, rd_out}, 32'd0);
    check("mis_data", wb_data_out, 32'd0);
    @(negedge clk);
    check("mis_pulse_end", {31'd0, align_err}, 32'd0);
    run_op(32'h11, 32'hBAD0BAD0, 5'd0, 1'b0, 1'b1);
    @(negedge clk);
    check("mis_st_align", {31'd0, align_err}, 32'd1);
    run_op(32'h10, 32'h0, 5'd8, 1'b1, 1'b0);
    @(negedge clk);
    check("mis_mem_kept", wb_data_out, 32'hDEADBEEF);

    // Address wrap: 0x400 aliases word 0.
    run_op(32'h400, 32'hA5A5A5A5, 5'd0, 1'b0, 1'b1);
    run_op(32'h0, 32'h0, 5'd2, 1'b1, 1'b0);
    @(negedge clk);
    check("wrap_data", wb_data_out, 32'hA5A5A5A5);
    check("wrap_rd", {27'd0, rd_out}, 32'd2);

    // Abort a store to 0x30 with reset mid-access.
    run_op(32'h30, 32'h11111111, 5'd0, 1'b0, 1'b1);
    run_op(32'h55, 32'h0, 5'd5, 1'b0, 1'b0);
    addr_in       = 32'h30;
    store_data_in = 32'h22222222;
    mem_write     = 1'b1;
    @(posedge clk);
    #2;
    check("abort_in_access", {31'd0, stall}, 32'd1);
    check("abort_pre_rd", {27'd0, rd_out}, 32'd5);
    rst = 1'b1;
    #1;
    check("abort_stall", {31'd0, stall}, 32'd0);
    check("abort_data", wb_data_out, 32'd0);
    check("abort_rd", {27'd0, rd_out}, 32'd0);
    check("abort_valid", {31'd0, wb_valid}, 32'd0);
    drive_nop();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    run_op(32'h30, 32'h0, 5'd1, 1'b1, 1'b0);
    @(negedge clk);
    check("abort_mem_kept", wb_data_out, 32'h11111111);
    check("abort_ld_valid", {31'd0, wb_valid}, 32'd1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  // Absolute time bound so the bench always terminates.
  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage that consumes the EX/MEM pipeline register outputs (ALU result/address, store data, destination register) and produces registered writeback data for MEM/WB. It owns a word-addressed data memory with a fixed multi-cycle access latency. It issues a stall back to the EX/MEM side while an access is in progress. Non-memory instructions pass through in one cycle.

## Interface
- `DEPTH`, default 256: data memory size in 32-bit words; must be a power of 2.
- `LATENCY`, default 2: memory access cycles; must be ≥1.
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `addr_in` in 32: ALU result from EX/MEM; used as the byte address for memory ops.
- `store_data_in` in 32: store data from EX/MEM.
- `rd_in` in 5: destination register from EX/MEM.
- `mem_read` in 1: load request.
- `mem_write` in 1: store request.
- `stall` out 1: combinational; high means EX/MEM must hold its outputs.
- `wb_data_out` out 32: registered writeback data.
- `rd_out` out 5: registered destination register.
- `wb_valid` out 1: registered; high means MEM/WB should write `rd_out`.
- `align_err` out 1: registered one-cycle pulse for a misaligned memory op.

## Operation
- States: IDLE and ACCESS. A down-counter `cnt` has width `clog2(LATENCY)+1`.
- Memory op is defined as `mem_read | mem_write`. If both are high, the op is a write and the read is ignored.
- Word index is `addr_in[clog2(DEPTH)+1:2]`. Upper address bits are ignored, so addresses wrap modulo `DEPTH*4`.
- Misaligned means `addr_in[1:0] != 0`.
- IDLE, no memory op:
  - Next edge: `wb_data_out <= addr_in`, `rd_out <= rd_in`, `wb_valid <= (rd_in != 0)`, `align_err <= 0`.
  - `stall` = 0.
- IDLE, misaligned memory op:
  - No memory access and no stall.
  - Next edge: `align_err <= 1`, `wb_valid <= 0`, `rd_out <= 0`, `wb_data_out <= 0`.
- IDLE, aligned memory op:
  - `stall` = 1 in this cycle.
  - Next edge: latch address, store data, `rd_in`, and op type; `cnt <= LATENCY-1`; go to ACCESS; `wb_valid <= 0`, `align_err <= 0`.
- ACCESS, `cnt != 0`:
  - `stall` = 1.
  - Next edge: `cnt <= cnt-1`; outputs hold `wb_valid` = 0.
- ACCESS, `cnt == 0` (final cycle):
  - `stall` = 0.
  - Next edge for a write: `mem[idx] <= latched data`, `wb_valid <= 0`, `rd_out <= 0`.
  - Next edge for a read: `wb_data_out <= mem[idx]`, `rd_out <= latched rd`, `wb_valid <= (latched rd != 0)`.
  - Go to IDLE.
- Only latched copies are used in ACCESS. Input changes during ACCESS have no effect.
- A read that follows a write to the same index sees the written data, because the accesses are strictly serialized.

## Timing
- Reset (async, immediate): state IDLE, `cnt` = 0. `wb_data_out` = 0, `rd_out` = 0, `wb_valid` = 0, `align_err` = 0.
- With `rst` high, `stall` = 0. Memory contents are not affected by reset.
- Reset mid-ACCESS aborts the op. A pending write is not performed.
- Non-memory and misaligned ops: 1-edge latency, zero stall cycles.
- Aligned memory op presented at edge N−1:
  - `stall` is high for cycles N … N+LATENCY−1.
  - Result is registered at edge N+LATENCY; `wb_valid` is visible in cycle N+LATENCY.
  - Total latency is `LATENCY+1` edges.
- Upstream advances on the edge where `stall` is low, i.e. the final ACCESS cycle. The following IDLE cycle sees the next instruction.
- `stall` depends only on state, `cnt`, `rst`, `mem_read`, `mem_write` and `addr_in[1:0]`. It has no path from memory data.

## Test plan
- Reset, then hold inputs with no memory op (`addr_in`=0x1234, `rd_in`=5) -> after 1 edge `wb_data_out`=0x1234, `rd_out`=5, `wb_valid`=1, `stall` never asserted.
- Store 0xDEADBEEF to 0x10 with `LATENCY`=2 -> `stall` high for exactly 2 cycles, `wb_valid` stays 0. A following load from 0x10 with `rd_in`=7 -> `wb_data_out`=0xDEADBEEF, `rd_out`=7, `wb_valid`=1, three edges after the load is presented.
- Load with `rd_in`=0 -> data is returned but `wb_valid`=0. Store and load both high at 0x20 -> treated as a store; a later load from 0x20 returns the store data.
- Misaligned load at 0x13 -> `align_err` pulses for 1 cycle, `stall`=0, `wb_valid`=0, memory unchanged.
- Wrap: store 0xA5A5A5A5 to 0x400 with `DEPTH`=256 -> a load from 0x000 returns 0xA5A5A5A5.
- Assert `rst` during the ACCESS of a store to 0x30 -> all outputs 0 immediately and `stall`=0. A later load from 0x30 returns the prior contents, not the aborted data.
